// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: feeder FSM states,
// skewer lane depth and default sizing constants.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STREAM,
      FLUSH
   } feeder_state_t;

   localparam int DEFAULT_MATRIX_SIZE = 2;

   // Depth of skewer lane i; the deepest lane (i = n-1) sets the flush length.
   function automatic int skew_depth(input int i, input int n);
      return 4 * i + n;
   endfunction

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEFAULT_FLUSH_CYCLES = skew_depth(DEFAULT_MATRIX_SIZE - 1, DEFAULT_MATRIX_SIZE);

endpackage

// File: rtl/feeder_buffer.sv
// N x N operand register bank: written one full row per cycle, read one full
// column per cycle. Contents are deliberately not reset.
module feeder_buffer
   import systolic_pkg::*;
#(
   parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
   parameter int DATA_SIZE   = 32
)(
   input  logic                               clk,
   input  logic                               we,
   input  logic [cnt_width(MATRIX_SIZE)-1:0]  wr_row,
   input  logic [MATRIX_SIZE*DATA_SIZE-1:0]   wr_data,
   input  logic [cnt_width(MATRIX_SIZE)-1:0]  rd_col,
   output logic [MATRIX_SIZE*DATA_SIZE-1:0]   rd_data
);

   logic [DATA_SIZE-1:0] mem [MATRIX_SIZE][MATRIX_SIZE];

   // Capture a whole row; element j of the row lands in column j.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int j = 0; j < MATRIX_SIZE; j++) begin
            mem[wr_row][j] <= wr_data[j*DATA_SIZE +: DATA_SIZE];
         end
      end
   end

   // Element i of the read vector is row i of the selected column.
   genvar gi;
   generate
      for (gi = 0; gi < MATRIX_SIZE; gi++) begin : g_col
         assign rd_data[gi*DATA_SIZE +: DATA_SIZE] = mem[gi][rd_col];
      end
   endgenerate

endmodule

// File: rtl/systolic_input_feeder.sv
// Input feeder ahead of the skewer: buffers an N x N matrix row by row, then
// streams it column by column with the shift enable, followed by zero flush
// cycles that drain the deepest skewer lane.
// Optional macro SYSTOLIC_FEEDER_DOUBLE_BUF_EN: ping-pong banks so the next
// matrix loads while the current one streams, enabling back-to-back matrices.
module systolic_input_feeder
   import systolic_pkg::*;
#(
   parameter int MATRIX_SIZE  = DEFAULT_MATRIX_SIZE,
   parameter int DATA_SIZE    = 32,
   parameter int FLUSH_CYCLES = skew_depth(MATRIX_SIZE - 1, MATRIX_SIZE)
)(
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [MATRIX_SIZE*DATA_SIZE-1:0] in_row,
   output logic [MATRIX_SIZE*DATA_SIZE-1:0] data_out,
   output logic                             enable_out,
   output logic                             busy,
   output logic                             done
);

   localparam int IW = cnt_width(MATRIX_SIZE);
   localparam int FW = cnt_width(FLUSH_CYCLES);
   localparam logic [IW-1:0] LAST_IDX   = IW'(MATRIX_SIZE - 1);
   localparam logic [FW-1:0] LAST_FLUSH = FW'(FLUSH_CYCLES - 1);

   feeder_state_t state_reg, state_next;
   logic [IW-1:0] row_cnt_reg, row_cnt_next;
   logic [IW-1:0] col_cnt_reg, col_cnt_next;
   logic [FW-1:0] flush_cnt_reg, flush_cnt_next;
   logic          done_reg, done_next;
   logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data;

   logic beat, row_last, complete;
   assign beat     = in_valid && in_ready;
   assign row_last = (row_cnt_reg == LAST_IDX);
   assign complete = beat && row_last;

`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
   logic [1:0] full_reg, full_next;
   logic       load_sel_reg, load_sel_next;
   logic       rd_sel_reg, rd_sel_next;
   logic       other_ready;
   logic [MATRIX_SIZE*DATA_SIZE-1:0] bank_data [2];

   assign in_ready = !reset && !full_reg[load_sel_reg];

   // The bank not currently streaming is ready (or completes this cycle).
   assign other_ready = full_reg[!rd_sel_reg] || (complete && (load_sel_reg != rd_sel_reg));

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         feeder_buffer #(
            .MATRIX_SIZE (MATRIX_SIZE),
            .DATA_SIZE   (DATA_SIZE)
         ) u_buf (
            .clk     (clk),
            .we      (beat && (load_sel_reg == 1'(gi))),
            .wr_row  (row_cnt_reg),
            .wr_data (in_row),
            .rd_col  (col_cnt_reg),
            .rd_data (bank_data[gi])
         );
      end
   endgenerate

   assign col_data = bank_data[rd_sel_reg];
`else
   assign in_ready = !reset && ((state_reg == IDLE) || (state_reg == LOAD));

   feeder_buffer #(
      .MATRIX_SIZE (MATRIX_SIZE),
      .DATA_SIZE   (DATA_SIZE)
   ) u_buf (
      .clk     (clk),
      .we      (beat),
      .wr_row  (row_cnt_reg),
      .wr_data (in_row),
      .rd_col  (col_cnt_reg),
      .rd_data (col_data)
   );
`endif

   assign enable_out = !reset && ((state_reg == STREAM) || (state_reg == FLUSH));
   assign data_out   = (!reset && (state_reg == STREAM)) ? col_data : '0;
   assign busy       = !reset && (state_reg != IDLE);
   assign done       = !reset && done_reg;

   // Next-state logic: row loading, column streaming and flush sequencing.
   always_comb begin
      state_next     = state_reg;
      row_cnt_next   = row_cnt_reg;
      col_cnt_next   = col_cnt_reg;
      flush_cnt_next = flush_cnt_reg;
      done_next      = 1'b0;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
      full_next     = full_reg;
      load_sel_next = load_sel_reg;
      rd_sel_next   = rd_sel_reg;
`endif

      if (beat) begin
         if (row_last) begin
            row_cnt_next = '0;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
            full_next[load_sel_reg] = 1'b1;
            load_sel_next           = !load_sel_reg;
`endif
         end else begin
            row_cnt_next = row_cnt_reg + 1'b1;
         end
      end

      case (state_reg)
         IDLE, LOAD: begin
            if (complete) begin
               state_next   = STREAM;
               col_cnt_next = '0;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
               rd_sel_next  = load_sel_reg;
`endif
            end else if (beat) begin
               state_next = LOAD;
            end
         end
         STREAM: begin
            if (col_cnt_reg == LAST_IDX) begin
               col_cnt_next   = '0;
               flush_cnt_next = '0;
               state_next     = FLUSH;
            end else begin
               col_cnt_next = col_cnt_reg + 1'b1;
            end
         end
         FLUSH: begin
            if (flush_cnt_reg == LAST_FLUSH) begin
               flush_cnt_next = '0;
               done_next      = 1'b1;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
               full_next[rd_sel_reg] = 1'b0;
               if (other_ready) begin
                  state_next   = STREAM;
                  rd_sel_next  = !rd_sel_reg;
                  col_cnt_next = '0;
               end else if (row_cnt_next != '0) begin
                  state_next = LOAD;
               end else begin
                  state_next = IDLE;
               end
`else
               state_next = IDLE;
`endif
            end else begin
               flush_cnt_next = flush_cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, counter and pulse registers; reset aborts any matrix in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         row_cnt_reg   <= '0;
         col_cnt_reg   <= '0;
         flush_cnt_reg <= '0;
         done_reg      <= 1'b0;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
         full_reg      <= '0;
         load_sel_reg  <= 1'b0;
         rd_sel_reg    <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         row_cnt_reg   <= row_cnt_next;
         col_cnt_reg   <= col_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
         done_reg      <= done_next;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
         full_reg      <= full_next;
         load_sel_reg  <= load_sel_next;
         rd_sel_reg    <= rd_sel_next;
`endif
      end
   end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed bench for systolic_input_feeder with N=2, 32-bit data, 6 flush cycles.
module tb_systolic_input_feeder;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int FC = 6;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] in_row;
   logic [N*DW-1:0] data_out;
   logic            enable_out;
   logic            busy;
   logic            done;

   int check_cnt = 0;
   int pass_cnt  = 0;

   systolic_input_feeder #(
      .MATRIX_SIZE  (N),
      .DATA_SIZE    (DW),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_row     (in_row),
      .data_out   (data_out),
      .enable_out (enable_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Element 0 in the low word, element 1 in the high word.
   function automatic logic [N*DW-1:0] pk(input int e0, input int e1);
      return {DW'(e1), DW'(e0)};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load2(input logic [N*DW-1:0] r0, input logic [N*DW-1:0] r1);
      in_valid = 1'b1; in_row = r0;
      check("load ready r0", 64'(in_ready), 64'd1);
      tick();
      in_row = r1;
      check("load ready r1", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // Checks the N stream + FC flush cycles, ending in the done cycle.
   task automatic stream_check(input string tag, input logic [N*DW-1:0] c0, input logic [N*DW-1:0] c1);
      logic [N*DW-1:0] exp;
      for (int k = 0; k < N + FC; k++) begin
         exp = (k == 0) ? c0 : (k == 1) ? c1 : '0;
         check({tag, " data"}, 64'(data_out), 64'(exp));
         check({tag, " en"}, 64'(enable_out), 64'd1);
         check({tag, " done low"}, 64'(done), 64'd0);
         check({tag, " busy"}, 64'(busy), 64'd1);
`ifndef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
         check({tag, " ready low"}, 64'(in_ready), 64'd0);
`endif
         $display("%s cycle %0d data=%0h en=%0b", tag, k, data_out, enable_out);
         tick();
      end
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " en off"}, 64'(enable_out), 64'd0);
      check({tag, " ready back"}, 64'(in_ready), 64'd1);
      check({tag, " idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset held two cycles with a valid row presented.
      reset = 1'b1; in_valid = 1'b1; in_row = pk(7, 7);
      for (int c = 0; c < 2; c++) begin
         tick();
         check("rst ready", 64'(in_ready), 64'd0);
         check("rst en", 64'(enable_out), 64'd0);
         check("rst data", 64'(data_out), 64'd0);
         check("rst busy", 64'(busy), 64'd0);
         check("rst done", 64'(done), 64'd0);
         $display("reset cycle %0d ready=%0b", c, in_ready);
      end
      reset = 1'b0; in_valid = 1'b0;
      #1;
      check("post rst ready", 64'(in_ready), 64'd1);
      check("post rst busy", 64'(busy), 64'd0);
      tick();
      check("no capture", 64'(busy), 64'd0);

`ifndef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
      // Basic matrix.
      load2(pk(1, 2), pk(3, 4));
      stream_check("basic", pk(1, 3), pk(2, 4));
      tick();
      check("done one cycle", 64'(done), 64'd0);

      // Gapped valid: 1,0,0,1.
      in_valid = 1'b1; in_row = pk(9, 8);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("gap hold busy", 64'(busy), 64'd1);
      check("gap hold en", 64'(enable_out), 64'd0);
      check("gap hold data", 64'(data_out), 64'd0);
      in_valid = 1'b1; in_row = pk(7, 6);
      tick();
      in_valid = 1'b0;
      stream_check("gap", pk(9, 7), pk(8, 6));
      tick();

      // Valid held through stream/flush; the row enters only after done.
      load2(pk(1, 2), pk(3, 4));
      in_valid = 1'b1; in_row = pk(5, 5);
      stream_check("hold", pk(1, 3), pk(2, 4));
      tick();
      in_valid = 1'b0;
      check("hold captured", 64'(busy), 64'd1);
      in_valid = 1'b1; in_row = pk(1, 1);
      tick();
      in_valid = 1'b0;
      stream_check("hold row0", pk(5, 1), pk(5, 1));
      tick();

      // Reset during the second stream cycle aborts without done.
      load2(pk(1, 2), pk(3, 4));
      check("abort col0", 64'(data_out), 64'(pk(1, 3)));
      tick();
      reset = 1'b1;
      #1;
      check("abort rst en", 64'(enable_out), 64'd0);
      check("abort rst data", 64'(data_out), 64'd0);
      tick();
      reset = 1'b0;
      #1;
      check("abort idle", 64'(busy), 64'd0);
      check("abort en", 64'(enable_out), 64'd0);
      check("abort data", 64'(data_out), 64'd0);
      check("abort no done", 64'(done), 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("abort quiet done", 64'(done), 64'd0);
         check("abort quiet en", 64'(enable_out), 64'd0);
      end
      load2(pk(1, 2), pk(3, 4));
      stream_check("after abort", pk(1, 3), pk(2, 4));
      tick();
`else
      // Back-to-back matrices through the ping-pong banks.
      begin
         int done_seen;
         logic [N*DW-1:0] exp;
         done_seen = 0;
         load2(pk(1, 2), pk(3, 4));
         for (int k = 0; k < 2 * (N + FC); k++) begin
            in_valid = (k == 2) || (k == 3);
            in_row   = (k == 2) ? pk(5, 6) : pk(7, 8);
            case (k)
               0: exp = pk(1, 3);
               1: exp = pk(2, 4);
               8: exp = pk(5, 7);
               9: exp = pk(6, 8);
               default: exp = '0;
            endcase
            check("dbuf data", 64'(data_out), 64'(exp));
            check("dbuf en", 64'(enable_out), 64'd1);
            check("dbuf done", 64'(done), 64'((k == N + FC) ? 1 : 0));
            if (done) done_seen++;
            $display("dbuf cycle %0d data=%0h en=%0b done=%0b", k, data_out, enable_out, done);
            tick();
         end
         in_valid = 1'b0;
         check("dbuf final done", 64'(done), 64'd1);
         if (done) done_seen++;
         check("dbuf en off", 64'(enable_out), 64'd0);
         check("dbuf done count", 64'(done_seen), 64'd2);
         tick();
         check("dbuf idle", 64'(busy), 64'd0);
      end
`endif

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
